// File: rtl/vo_pkg.sv
// Shared types and widths for the visual-odometry front-end frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vo_pkg;

  localparam int PIX_W   = 8;
  localparam int DEPTH_W = 16;
  localparam int COOR_W  = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN
  } sched_state_t;

endpackage

// File: rtl/vo_pix_counter.sv
// Raster position counter: x runs 0..WIDTH-1, y advances on each x wrap.
// Latency: position updates on the clock edge after inc; last_pixel is combinational from position.
// Backpressure: none, the owner only pulses inc for pixels it has actually taken.
module vo_pix_counter
  import vo_pkg::*;
#(
  parameter logic [COOR_W-1:0] WIDTH  = 12'd640,
  parameter logic [COOR_W-1:0] HEIGHT = 12'd480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic last_pixel
);

  logic [COOR_W-1:0] x;
  logic [COOR_W-1:0] y;

  // Advance the raster position; clear takes precedence over inc.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == WIDTH - 12'd1) begin
        x <= '0;
        y <= (y == HEIGHT - 12'd1) ? '0 : y + 12'd1;
      end else begin
        x <= x + 12'd1;
      end
    end
  end

  assign last_pixel = (x == WIDTH - 12'd1) && (y == HEIGHT - 12'd1);

endmodule

// File: rtl/vo_frame_scheduler.sv
// Frame sequencer: admits WIDTH*HEIGHT host beats per frame, pulses frame start, waits for MATCH frame end.
// Latency: first pixel is replayed from a holding register; later pixels appear one cycle after acceptance.
// Backpressure: o_host_ready follows i_pipe_ready while streaming; no accepted beat is ever dropped.
module vo_frame_scheduler
  import vo_pkg::*;
#(
  parameter logic [COOR_W-1:0] WIDTH         = 12'd640,
  parameter logic [COOR_W-1:0] HEIGHT        = 12'd480,
  parameter logic [23:0]       DRAIN_TIMEOUT = 24'd2000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_host_valid,
  input  logic               i_host_sof,
  input  logic [PIX_W-1:0]   i_host_pixel,
  input  logic [DEPTH_W-1:0] i_host_depth,
  output logic               o_host_ready,
  input  logic               i_abort,
  input  logic               i_pipe_ready,
  input  logic               i_match_frame_end,
  output logic               o_frame_start,
  output logic               o_valid,
  output logic [PIX_W-1:0]   o_pixel,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_busy,
  output logic [15:0]        o_frame_cnt,
  output logic               o_err_sof,
  output logic               o_err_timeout
);

  sched_state_t        state;
  sched_state_t        state_nxt;
  logic                host_ready;
  logic                frame_start;
  logic                frame_done;
  logic                drain_to;
  logic                abort_act;
  logic                accept;
  logic                take;
  logic                last_pixel;
  logic                held_pend;   // first pixel of the frame still waiting to be emitted
  logic                all_taken;   // every pixel of the frame has been taken, last one emitting
  logic [PIX_W-1:0]    hold_pix;
  logic [DEPTH_W-1:0]  hold_dep;
  logic                out_vld;
  logic [PIX_W-1:0]    out_pix;
  logic [DEPTH_W-1:0]  out_dep;
  logic [23:0]         drain_tmr;
  logic [15:0]         frame_cnt;
  logic                err_sof;
  logic                err_timeout;

  assign abort_act = i_abort && (state != S_IDLE);
  assign accept    = i_host_valid && host_ready;
  // A pixel is taken either when the held first pixel is emitted or when a host beat is accepted.
  assign take      = (state == S_STREAM) && !abort_act &&
                     ((held_pend && i_pipe_ready) || accept);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake decode; abort overrides every normal transition.
  always_comb begin
    state_nxt   = state;
    host_ready  = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    drain_to    = 1'b0;
    case (state)
      S_IDLE: begin
        // Ready is held low during reset so no beat is accepted and then discarded.
        host_ready = i_rst_n;
        if (i_host_valid && i_host_sof) state_nxt = S_START;
      end
      S_START: begin
        frame_start = 1'b1;
        state_nxt   = S_STREAM;
      end
      S_STREAM: begin
        host_ready = i_rst_n && i_pipe_ready && !held_pend && !all_taken;
        if (all_taken) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Frame end wins over a coincident timeout.
        if (i_match_frame_end) begin
          frame_done = 1'b1;
          state_nxt  = S_IDLE;
        end else if (drain_tmr == DRAIN_TIMEOUT - 24'd1) begin
          drain_to  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) begin
      state_nxt  = S_IDLE;
      host_ready = 1'b0;
      frame_done = 1'b0;
      drain_to   = 1'b0;
    end
  end

  // Holding register for the sof beat, replayed as the first pixel of STREAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      held_pend <= 1'b0;
      hold_pix  <= '0;
      hold_dep  <= '0;
    end else if (state == S_IDLE && accept && i_host_sof) begin
      held_pend <= 1'b1;
      hold_pix  <= i_host_pixel;
      hold_dep  <= i_host_depth;
    end else if (abort_act || (take && held_pend)) begin
      held_pend <= 1'b0;
    end
  end

  // Output pipeline register for beats accepted while streaming.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_vld <= 1'b0;
      out_pix <= '0;
      out_dep <= '0;
    end else begin
      out_vld <= (state == S_STREAM) && accept;
      if ((state == S_STREAM) && accept) begin
        out_pix <= i_host_pixel;
        out_dep <= i_host_depth;
      end
    end
  end

  // Flag that the last raster pixel has been taken; leaves one cycle for it to emit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state != S_STREAM) all_taken <= 1'b0;
    else if (take && last_pixel)       all_taken <= 1'b1;
  end

  // Drain timer counts cycles spent in DRAIN.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state != S_DRAIN) drain_tmr <= '0;
    else                              drain_tmr <= drain_tmr + 24'd1;
  end

  // Host-visible frame count and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_cnt   <= '0;
      err_sof     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (drain_to)   err_timeout <= 1'b1;
      if ((state == S_IDLE && accept && !i_host_sof) ||
          (state == S_STREAM && accept && i_host_sof))
        err_sof <= 1'b1;
    end
  end

  vo_pix_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pix_counter (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clear      (state == S_START),
    .inc        (take),
    .last_pixel (last_pixel)
  );

  assign o_host_ready  = host_ready;
  assign o_frame_start = frame_start;
  assign o_valid       = (state == S_STREAM) && (held_pend ? i_pipe_ready : out_vld);
  assign o_pixel       = held_pend ? hold_pix : out_pix;
  assign o_depth       = held_pend ? hold_dep : out_dep;
  assign o_busy        = (state != S_IDLE);
  assign o_frame_cnt   = frame_cnt;
  assign o_err_sof     = err_sof;
  assign o_err_timeout = err_timeout;

endmodule

// File: tb/tb_vo_frame_scheduler.sv
// Directed bench for the frame scheduler with a small 8x4 frame and a 50-cycle drain timeout.
// Latency: n/a.
// Backpressure: exercised through i_pipe_ready patterns.
module tb_vo_frame_scheduler;

  localparam int NPIX = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_host_valid;
  logic        i_host_sof;
  logic [7:0]  i_host_pixel;
  logic [15:0] i_host_depth;
  logic        o_host_ready;
  logic        i_abort;
  logic        i_pipe_ready;
  logic        i_match_frame_end;
  logic        o_frame_start;
  logic        o_valid;
  logic [7:0]  o_pixel;
  logic [15:0] o_depth;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic        o_err_sof;
  logic        o_err_timeout;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  vo_frame_scheduler #(
    .WIDTH         (12'd8),
    .HEIGHT        (12'd4),
    .DRAIN_TIMEOUT (24'd50)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_host_valid      (i_host_valid),
    .i_host_sof        (i_host_sof),
    .i_host_pixel      (i_host_pixel),
    .i_host_depth      (i_host_depth),
    .o_host_ready      (o_host_ready),
    .i_abort           (i_abort),
    .i_pipe_ready      (i_pipe_ready),
    .i_match_frame_end (i_match_frame_end),
    .o_frame_start     (o_frame_start),
    .o_valid           (o_valid),
    .o_pixel           (o_pixel),
    .o_depth           (o_depth),
    .o_busy            (o_busy),
    .o_frame_cnt       (o_frame_cnt),
    .o_err_sof         (o_err_sof),
    .o_err_timeout     (o_err_timeout)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=running need=done");
    $fatal(1);
  end

  typedef struct {
    logic        rst_n, hv, sof;
    logic [7:0]  pix;
    logic [15:0] dep;
    logic        pr, ab, fe;
    logic [5:0]  eflags;   // {ready, frame_start, valid, busy, err_sof, err_timeout}
    logic [15:0] ecnt;
    logic [7:0]  epix;
    logic [15:0] edep;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, hv, sof, input logic [7:0] pix,
                              input logic [15:0] dep, input logic pr, ab, fe,
                              input logic [5:0] eflags, input logic [15:0] ecnt,
                              input logic [7:0] epix, input logic [15:0] edep);
    vec_t v;
    v.rst_n = rst_n; v.hv = hv; v.sof = sof; v.pix = pix; v.dep = dep;
    v.pr = pr; v.ab = ab; v.fe = fe; v.eflags = eflags; v.ecnt = ecnt;
    v.epix = epix; v.edep = edep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Drives one 32-pixel frame and observes the output stream.
  // kill: 0 none, 1 abort at beat 12, 2 reset at beat 12. fe_at: drain cycle index for frame_end (-1 none).
  task automatic run_frame(input logic [7:0] base, input bit bp, input int fe_at, input int kill,
                           output int nvld, output int nstart, output int exit_dk, output int nbad);
    int idx, c, dk;
    bit draining, done, killing;
    nvld = 0; nstart = 0; exit_dk = -1; nbad = 0;
    idx = 1; c = 0; dk = 0; draining = 0; done = 0; killing = 0;
    i_host_valid = 1'b1; i_host_sof = 1'b1; i_host_pixel = base; i_host_depth = {base, 8'h00};
    i_pipe_ready = 1'b1;
    #1;
    if (o_host_ready !== 1'b1) nbad++;
    @(negedge i_clk);
    while (!done && c < 300) begin
      i_pipe_ready      = bp ? (((c / 3) % 2) == 0) : 1'b1;
      i_host_valid      = (idx < NPIX);
      i_host_sof        = 1'b0;
      i_host_pixel      = base + 8'(idx);
      i_host_depth      = {base, 8'(idx)};
      i_match_frame_end = draining && (dk == fe_at);
      killing           = (kill != 0) && (idx == 12);
      i_abort           = (kill == 1) && killing;
      i_rst_n           = !((kill == 2) && killing);
      #1;
      if (o_frame_start) nstart++;
      if (!killing && nvld >= 1 && idx < NPIX && o_host_ready !== i_pipe_ready) nbad++;
      if (o_valid) begin
        if (o_pixel !== base + 8'(nvld) || o_depth !== {base, 8'(nvld)}) nbad++;
        nvld++;
      end
      if (draining && !o_busy) begin
        exit_dk = dk;
        done = 1;
      end
      if (i_host_valid && o_host_ready) idx++;
      @(negedge i_clk);
      c++;
      if (killing) begin
        i_abort = 1'b0;
        i_rst_n = 1'b1;
        done = 1;
      end
      if (draining) dk++;
      else if (nvld == NPIX) draining = 1;
    end
    i_host_valid = 1'b0; i_host_sof = 1'b0; i_match_frame_end = 1'b0; i_pipe_ready = 1'b1;
  endtask

  vec_t tbl [18];

  initial begin
    int nvld, nstart, exit_dk, nbad;

    //             rst hv sof pix    dep       pr ab fe  flags      cnt  epix   edep
    tbl[0]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b000000, 0, 8'h00, 16'h0000);
    tbl[1]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b100000, 0, 8'h00, 16'h0000);
    tbl[2]  = mk(1, 1, 0, 8'h11, 16'h0011, 0, 0, 0, 6'b100000, 0, 8'h00, 16'h0000);
    tbl[3]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 6'b100010, 0, 8'h00, 16'h0000);
    tbl[4]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b000010, 0, 8'h00, 16'h0000);
    tbl[5]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b100000, 0, 8'h00, 16'h0000);
    tbl[6]  = mk(1, 1, 1, 8'hA0, 16'h1000, 0, 0, 0, 6'b100000, 0, 8'h00, 16'h0000);
    tbl[7]  = mk(1, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 6'b010100, 0, 8'h00, 16'h0000);
    tbl[8]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b000100, 0, 8'h00, 16'h0000);
    tbl[9]  = mk(1, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 6'b001100, 0, 8'hA0, 16'h1000);
    tbl[10] = mk(1, 1, 0, 8'hA1, 16'h1001, 1, 0, 0, 6'b100100, 0, 8'h00, 16'h0000);
    tbl[11] = mk(1, 1, 1, 8'hA2, 16'h1002, 1, 0, 0, 6'b101100, 0, 8'hA1, 16'h1001);
    tbl[12] = mk(1, 1, 0, 8'hA3, 16'h1003, 0, 0, 0, 6'b001110, 0, 8'hA2, 16'h1002);
    tbl[13] = mk(1, 1, 0, 8'hA3, 16'h1003, 1, 0, 0, 6'b100110, 0, 8'h00, 16'h0000);
    tbl[14] = mk(1, 1, 0, 8'hA4, 16'h1004, 1, 1, 0, 6'b001110, 0, 8'hA3, 16'h1003);
    tbl[15] = mk(1, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 6'b100010, 0, 8'h00, 16'h0000);
    tbl[16] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b000010, 0, 8'h00, 16'h0000);
    tbl[17] = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 6'b100000, 0, 8'h00, 16'h0000);

    i_rst_n = 1'b0; i_host_valid = 1'b0; i_host_sof = 1'b0; i_host_pixel = '0; i_host_depth = '0;
    i_abort = 1'b0; i_pipe_ready = 1'b0; i_match_frame_end = 1'b0;
    repeat (3) @(negedge i_clk);

    // Cycle-by-cycle vectors: reset, missing sof, start pulse, held pixel, mid-frame sof, abort.
    for (int i = 0; i < 18; i++) begin
      i_rst_n = tbl[i].rst_n; i_host_valid = tbl[i].hv; i_host_sof = tbl[i].sof;
      i_host_pixel = tbl[i].pix; i_host_depth = tbl[i].dep; i_pipe_ready = tbl[i].pr;
      i_abort = tbl[i].ab; i_match_frame_end = tbl[i].fe;
      #1;
      chk($sformatf("vec%0d_flags_cnt", i),
          {10'd0, o_host_ready, o_frame_start, o_valid, o_busy, o_err_sof, o_err_timeout, o_frame_cnt},
          {10'd0, tbl[i].eflags, tbl[i].ecnt});
      if (tbl[i].eflags[3])
        chk($sformatf("vec%0d_data", i), {8'd0, o_pixel, o_depth}, {8'd0, tbl[i].epix, tbl[i].edep});
      @(negedge i_clk);
    end
    i_abort = 1'b0; i_match_frame_end = 1'b0; i_host_valid = 1'b0;

    // Nominal frame, frame_end 10 cycles after the last pixel.
    run_frame(8'h10, 0, 9, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("nom_beats", nvld, NPIX);
    chk("nom_start_pulses", nstart, 1);
    chk("nom_data_errs", nbad, 0);
    chk("nom_drain_exit", exit_dk, 10);
    chk("nom_cnt_busy", {o_frame_cnt, 15'd0, o_busy}, {16'd1, 16'd0});

    // Backpressure: pipe ready toggles every 3 cycles.
    run_frame(8'h40, 1, 9, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("bp_beats", nvld, NPIX);
    chk("bp_data_ready_errs", nbad, 0);
    chk("bp_cnt", o_frame_cnt, 2);

    // Missing sof: dropped, flagged, stays idle; then a normal frame.
    i_host_valid = 1'b1; i_host_sof = 1'b0; i_host_pixel = 8'h55;
    @(negedge i_clk);
    i_host_valid = 1'b0;
    #1;
    chk("nosof_err_busy", {o_err_sof, o_busy}, 2'b10);
    run_frame(8'h70, 0, 9, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("nosof_frame_beats_errs", {nvld[15:0], nbad[15:0]}, {16'd32, 16'd0});
    chk("nosof_cnt", o_frame_cnt, 3);

    // Drain timeout: no frame_end.
    run_frame(8'h90, 0, -1, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("to_drain_exit", exit_dk, 50);
    chk("to_err_cnt", {o_err_timeout, o_frame_cnt}, {1'b1, 16'd3});
    i_match_frame_end = 1'b1;
    @(negedge i_clk);
    i_match_frame_end = 1'b0;
    #1;
    chk("idle_fe_ignored", {o_busy, o_frame_cnt}, {1'b0, 16'd3});

    // Abort at beat 12, then a full frame must restart at raster origin.
    run_frame(8'hB0, 0, -1, 1, nvld, nstart, exit_dk, nbad);
    #1;
    chk("abort_idle", {o_busy, o_valid, o_frame_cnt}, {2'b00, 16'd3});
    run_frame(8'hC0, 0, 9, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("post_abort_beats_errs", {nvld[15:0], nbad[15:0]}, {16'd32, 16'd0});
    chk("post_abort_exit_cnt", {exit_dk[15:0], o_frame_cnt}, {16'd10, 16'd4});

    // Reset at beat 12: reset also clears the count and sticky flags.
    run_frame(8'hD0, 0, -1, 2, nvld, nstart, exit_dk, nbad);
    #1;
    chk("reset_idle", {o_busy, o_valid, o_err_sof, o_err_timeout, o_frame_cnt}, {4'b0000, 16'd0});
    run_frame(8'hE0, 0, 9, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("post_reset_beats_errs", {nvld[15:0], nbad[15:0]}, {16'd32, 16'd0});
    chk("post_reset_cnt", o_frame_cnt, 1);

    // frame_end on the same cycle the timeout would fire.
    run_frame(8'hF0, 0, 49, 0, nvld, nstart, exit_dk, nbad);
    #1;
    chk("simul_exit", exit_dk, 50);
    chk("simul_cnt_err", {o_err_timeout, o_frame_cnt}, {1'b0, 16'd2});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
